// File: rtl/seg_display_reader.sv
// Reads back a time-multiplexed, active-low seven-segment display and publishes the
// shown BCD digits once the same complete scan has repeated STABLE_SCANS times.
module seg_display_reader #(
    parameter int NUM_DIGITS   = 4,
    parameter int STABLE_SCANS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    sample_en,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic                    valid,
    output logic                    update,
    output logic                    err_pattern,
    output logic                    err_select
);

    localparam int          W          = 4 * NUM_DIGITS;
    localparam logic [3:0]  STABLE_MAX = 4'(STABLE_SCANS);
    localparam logic [3:0]  CODE_BLANK = 4'hF;
    localparam logic [3:0]  CODE_BAD   = 4'hE;

    typedef enum logic {
        ACQUIRE,
        LOCKED
    } state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          scanBuf_q, scanBuf_d;
    logic [W-1:0]          prevScan_q, prevScan_d;
    logic [W-1:0]          digits_q, digits_d;
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic [NUM_DIGITS-1:0] blankMask_q, blankMask_d;
    logic                  scanBad_q, scanBad_d;
    logic [3:0]            stableCnt_q, stableCnt_d;
    logic                  update_q, update_d;
    logic                  errPattern_q, errPattern_d;
    logic                  errSelect_q, errSelect_d;

    logic [3:0]            code;
    logic                  legalSel;
    logic [W-1:0]          newBuf;
    logic [NUM_DIGITS-1:0] newSeen;
    logic                  newBad;
    logic [3:0]            cntNext;
    logic                  publish;

    // Segment bit order is {g,f,e,d,c,b,a}, active low; anything unrecognised maps to CODE_BAD.
    function automatic logic [3:0] decodeSeg(input logic [6:0] seg);
        logic [3:0] result;
        case (seg)
            7'b1000000: result = 4'd0;
            7'b1111001: result = 4'd1;
            7'b0100100: result = 4'd2;
            7'b0110000: result = 4'd3;
            7'b0011001: result = 4'd4;
            7'b0010010: result = 4'd5;
            7'b0000010: result = 4'd6;
            7'b1111000: result = 4'd7;
            7'b0000000: result = 4'd8;
            7'b0011000: result = 4'd9;
            7'b1111111: result = CODE_BLANK;
            default:    result = CODE_BAD;
        endcase
        return result;
    endfunction

    assign code     = decodeSeg(seg_in);
    assign legalSel = $onehot(~an_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACQUIRE;
            scanBuf_q    <= '1;
            prevScan_q   <= '1;
            digits_q     <= '1;
            seen_q       <= '0;
            blankMask_q  <= '1;
            scanBad_q    <= 1'b0;
            stableCnt_q  <= '0;
            update_q     <= 1'b0;
            errPattern_q <= 1'b0;
            errSelect_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            scanBuf_q    <= scanBuf_d;
            prevScan_q   <= prevScan_d;
            digits_q     <= digits_d;
            seen_q       <= seen_d;
            blankMask_q  <= blankMask_d;
            scanBad_q    <= scanBad_d;
            stableCnt_q  <= stableCnt_d;
            update_q     <= update_d;
            errPattern_q <= errPattern_d;
            errSelect_q  <= errSelect_d;
        end
    end

    // The completing sample is folded into newBuf so the compare and publish see the whole scan.
    always_comb begin
        state_d      = state_q;
        scanBuf_d    = scanBuf_q;
        prevScan_d   = prevScan_q;
        digits_d     = digits_q;
        seen_d       = seen_q;
        blankMask_d  = blankMask_q;
        scanBad_d    = scanBad_q;
        stableCnt_d  = stableCnt_q;
        update_d     = 1'b0;
        errPattern_d = 1'b0;
        errSelect_d  = 1'b0;
        newBuf       = scanBuf_q;
        newSeen      = seen_q;
        newBad       = scanBad_q;
        cntNext      = stableCnt_q;
        publish      = 1'b0;

        if (clear) begin
            state_d     = ACQUIRE;
            scanBuf_d   = '1;
            prevScan_d  = '1;
            digits_d    = '1;
            seen_d      = '0;
            blankMask_d = '1;
            scanBad_d   = 1'b0;
            stableCnt_d = '0;
        end else if (sample_en) begin
            if (!legalSel) begin
                errSelect_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (!an_in[i]) begin
                        newBuf[4*i +: 4] = code;
                        newSeen[i]       = 1'b1;
                    end
                end
                if (code == CODE_BAD) begin
                    newBad       = 1'b1;
                    errPattern_d = 1'b1;
                end
                scanBuf_d = newBuf;
                if (&newSeen) begin
                    if (newBad) begin
                        cntNext = '0;
                    end else if (newBuf == prevScan_q) begin
                        cntNext = (stableCnt_q >= STABLE_MAX) ? STABLE_MAX : stableCnt_q + 4'd1;
                    end else begin
                        cntNext = 4'd1;
                    end
                    stableCnt_d = cntNext;
                    prevScan_d  = newBuf;
                    seen_d      = '0;
                    scanBad_d   = 1'b0;
                    publish     = (cntNext == STABLE_MAX) &&
                                  ((newBuf != digits_q) || (state_q == ACQUIRE));
                end else begin
                    seen_d    = newSeen;
                    scanBad_d = newBad;
                end
            end
        end

        if (publish) begin
            digits_d = newBuf;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                blankMask_d[i] = (newBuf[4*i +: 4] == CODE_BLANK);
            end
            update_d = 1'b1;
            state_d  = LOCKED;
        end
    end

    assign digits      = digits_q;
    assign blank_mask  = blankMask_q;
    assign valid       = (state_q == LOCKED);
    assign update      = update_q;
    assign err_pattern = errPattern_q;
    assign err_select  = errSelect_q;

endmodule

// File: tb/tb_seg_display_reader.sv
// Scoreboard bench for seg_display_reader: each expected publish is queued before the
// scan that should cause it and popped when the DUT pulses update.
module tb_seg_display_reader;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          sample_en;
    logic [6:0]    seg_in;
    logic [ND-1:0] an_in;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] blank_mask;
    logic          valid;
    logic          update;
    logic          err_pattern;
    logic          err_select;

    int errors = 0;
    int checks = 0;
    int patPulses = 0;
    int selPulses = 0;
    logic [19:0] expQ[$];
    logic [19:0] expEntry;

    seg_display_reader #(.NUM_DIGITS(ND), .STABLE_SCANS(3)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .sample_en(sample_en),
        .seg_in(seg_in), .an_in(an_in), .digits(digits), .blank_mask(blank_mask),
        .valid(valid), .update(update), .err_pattern(err_pattern), .err_select(err_select)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] encodeSeg(input logic [3:0] nib);
        case (nib)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0011000;
            4'hF: return 7'b1111111;
            default: return 7'b0101010;
        endcase
    endfunction

    // Monitor: samples outputs on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_pattern) patPulses++;
            if (err_select)  selPulses++;
            if (update) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousUpdate", 32'(update), 32'd0);
                end else begin
                    expEntry = expQ.pop_front();
                    checkOutput("publishDigits", 32'(digits), 32'(expEntry[19:4]));
                    checkOutput("publishBlank", 32'(blank_mask), 32'(expEntry[3:0]));
                    checkOutput("publishValid", 32'(valid), 32'd1);
                end
            end
        end
    end

    task automatic pushExpected(input logic [15:0] val);
        logic [3:0] bm;
        for (int k = 0; k < ND; k++) bm[k] = (val[4*k +: 4] == 4'hF);
        expQ.push_back({val, bm});
    endtask

    task automatic applyStimulus(input logic [6:0] seg, input logic [ND-1:0] an);
        @(negedge clk);
        sample_en = 1'b1;
        seg_in    = seg;
        an_in     = an;
        @(negedge clk);
        sample_en = 1'b0;
        seg_in    = '1;
        an_in     = '1;
    endtask

    task automatic applyDigit(input logic [15:0] val, input int k);
        logic [ND-1:0] an;
        an = '1;
        an[k] = 1'b0;
        applyStimulus(encodeSeg(val[4*k +: 4]), an);
    endtask

    task automatic applyScan(input logic [15:0] val);
        for (int k = 0; k < ND; k++) applyDigit(val, k);
    endtask

    task automatic settle(input string tag);
        repeat (2) @(negedge clk);
        checkOutput(tag, 32'(expQ.size()), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Digits"}, 32'(digits), 32'hFFFF);
        checkOutput({tag, "Blank"}, 32'(blank_mask), 32'hF);
        checkOutput({tag, "Valid"}, 32'(valid), 32'd0);
        checkOutput({tag, "Update"}, 32'(update), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; sample_en = 1'b0; seg_in = '1; an_in = '1;
        #12;
        checkResetValues("reset");
        checkOutput("resetErrPat", 32'(err_pattern), 32'd0);
        checkOutput("resetErrSel", 32'(err_select), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three scans of 1234 publish on the third
        applyScan(16'h1234);
        applyScan(16'h1234);
        checkOutput("notYetValid", 32'(valid), 32'd0);
        pushExpected(16'h1234);
        applyScan(16'h1234);
        settle("pend1234");
        checkOutput("valid1234", 32'(valid), 32'd1);

        // Interrupted run restarts the stability count
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        applyScan(16'h1234);
        applyScan(16'h1234);
        applyScan(16'h1235);
        applyScan(16'h1234);
        applyScan(16'h1234);
        checkOutput("interruptDigits", 32'(digits), 32'hFFFF);
        pushExpected(16'h1234);
        applyScan(16'h1234);
        settle("pendInterrupt");

        // Blank leading digit
        applyScan(16'hF987);
        applyScan(16'hF987);
        pushExpected(16'hF987);
        applyScan(16'hF987);
        settle("pendBlank");

        // Bad pattern mid-sequence
        applyScan(16'h1234);
        applyScan(16'h1234);
        applyScan(16'h12E4);
        checkOutput("errPatCount", 32'(patPulses), 32'd1);
        applyScan(16'h1234);
        applyScan(16'h1234);
        checkOutput("holdAfterBad", 32'(digits), 32'hF987);
        pushExpected(16'h1234);
        applyScan(16'h1234);
        settle("pendBad");

        // Illegal selects inside a scan do not disturb progress
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        applyScan(16'h1234);
        applyScan(16'h1234);
        pushExpected(16'h1234);
        applyDigit(16'h1234, 0);
        applyDigit(16'h1234, 1);
        applyStimulus(7'b0000000, 4'b1111);
        applyStimulus(7'b0000000, 4'b0011);
        applyDigit(16'h1234, 2);
        applyDigit(16'h1234, 3);
        settle("pendSelect");
        checkOutput("errSelCount", 32'(selPulses), 32'd2);
        checkOutput("errPatUnchanged", 32'(patPulses), 32'd1);

        // Async reset mid-scan
        applyDigit(16'h5678, 0);
        applyDigit(16'h5678, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetValues("midReset");
        @(negedge clk);
        rst_n = 1'b1;
        applyScan(16'h1234);
        applyScan(16'h1234);
        pushExpected(16'h1234);
        applyScan(16'h1234);
        settle("pendAfterReset");
        checkOutput("validAfterReset", 32'(valid), 32'd1);

        // Synchronous clear mid-scan; the concurrent sample must be ignored
        applyDigit(16'h5678, 0);
        @(negedge clk);
        clear = 1'b1; sample_en = 1'b1; seg_in = 7'b0000000; an_in = 4'b1110;
        @(negedge clk);
        checkResetValues("clear");
        clear = 1'b0; sample_en = 1'b0; seg_in = '1; an_in = '1;
        applyScan(16'h5678);
        applyScan(16'h5678);
        pushExpected(16'h5678);
        applyScan(16'h5678);
        settle("pendAfterClear");
        checkOutput("errPatFinal", 32'(patPulses), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
